// File: rtl/boot_loader_writer_if.sv
// boot_loader_writer_if: byte-stream input, RAM write port and status bundle
interface boot_loader_writer_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, busy, done, err
    );
    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, busy, done, err
    );
endinterface

// File: rtl/boot_loader_writer.sv
// boot_loader_writer: loads a length-prefixed, XOR-checked byte frame into instruction RAM as big-endian words
module boot_loader_writer #(
    parameter int          ADDR_W  = 9,
    parameter int          DATA_W  = 32,
    parameter logic [23:0] TIMEOUT = 24'd5000000
) (
    input logic                clk,
    input logic                rst_n,
    boot_loader_writer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
    state_t              r_state, w_next;
    logic [1:0]          r_bcnt;
    logic [31:0]         r_n;
    logic [23:0]         r_shift;
    logic [7:0]          r_csum;
    logic [ADDR_W:0]     r_idx;
    logic [23:0]         r_timer;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;
    logic                r_err;
    logic                w_busy;
    logic                w_acc;
    logic                w_last_byte;
    logic                w_timeout;
    logic                w_set_done;
    logic                w_set_err;
    logic [31:0]         w_hdr_n;
    logic [ADDR_W:0]     w_idx_inc;

    assign w_busy      = r_state != S_IDLE;
    assign w_acc       = w_busy & bus.rx_valid;
    assign w_last_byte = w_acc & (r_bcnt == 2'd3);
    assign w_timeout   = w_busy & ~bus.rx_valid & (r_timer + 24'd1 == TIMEOUT);
    assign w_hdr_n     = {r_n[23:0], bus.rx_data};
    assign w_idx_inc   = r_idx + (ADDR_W+1)'(1);

    assign bus.rx_ready = w_busy;
    assign bus.busy     = w_busy;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and done/err set requests; a timeout overrides any busy state
    always_comb begin
        w_next     = r_state;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_next = S_HDR;
            S_HDR: if (w_last_byte) begin
                if (w_hdr_n == 32'd0) w_next = S_CSUM;
                else if (w_hdr_n > (32'd1 << ADDR_W)) begin
                    w_next    = S_IDLE;
                    w_set_err = 1'b1;
                end else w_next = S_DATA;
            end
            S_DATA: if (w_last_byte && 32'(w_idx_inc) == r_n) w_next = S_CSUM;
            S_CSUM: if (w_acc) begin
                w_next     = S_IDLE;
                w_set_done = bus.rx_data == r_csum;
                w_set_err  = bus.rx_data != r_csum;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next    = S_IDLE;
            w_set_err = 1'b1;
        end
    end

    // Byte assembly, checksum, idle timer, RAM write port and sticky status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_csum  <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_set_done) r_done <= 1'b1;
            if (w_set_err) r_err <= 1'b1;
            if (r_state == S_IDLE && bus.start) begin
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_bcnt  <= '0;
                r_n     <= '0;
                r_shift <= '0;
                r_csum  <= '0;
                r_idx   <= '0;
                r_timer <= '0;
            end
            if (w_busy) r_timer <= w_acc ? 24'd0 : r_timer + 24'd1;
            if (w_acc && r_state != S_CSUM) r_bcnt <= r_bcnt + 2'd1;
            if (w_acc && r_state == S_HDR) r_n <= w_hdr_n;
            if (w_acc && r_state == S_DATA) begin
                r_shift <= {r_shift[15:0], bus.rx_data};
                r_csum  <= r_csum ^ bus.rx_data;
            end
            if (w_last_byte && r_state == S_DATA) begin
                r_we    <= 1'b1;
                r_waddr <= r_idx[ADDR_W-1:0];
                r_wdata <= {r_shift, bus.rx_data};
                r_idx   <= w_idx_inc;
            end
        end
    end
endmodule

// File: tb/tb_boot_loader_writer.sv
// tb_boot_loader_writer: scoreboard bench for the boot frame loader
module tb_boot_loader_writer;
    localparam int          AW = 9;
    localparam logic [23:0] TO = 24'd40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    boot_loader_writer_if #(.ADDR_W(AW)) bus();
    boot_loader_writer #(.ADDR_W(AW), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          n_we  = 0;
    logic [40:0] sbq[$];
    logic [7:0]  pay[0:2047];
    logic [7:0]  csum;
    logic [31:0] wacc;
    int          widx;
    int          we_before;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // RAM write monitor: every strobe must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && bus.we === 1'b1) begin
            n_we++;
            if (sbq.size() == 0) check("we_unexpected", 64'(bus.we), 64'd0);
            else check("write", 64'({bus.waddr, bus.wdata}), 64'(sbq.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int bound;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        bound = 0;
        while (!bus.rx_ready && bound < 10) begin
            @(negedge clk);
            bound++;
        end
        if (bound >= 10) check("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic begin_frame();
        start_pulse();
        csum = 8'h00;
        widx = 0;
        wacc = 32'h0;
    endtask

    task automatic send_hdr(input logic [31:0] n);
        for (int i = 3; i >= 0; i--) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_data(input int nb);
        logic [7:0] b;
        for (int i = 0; i < nb; i++) begin
            b    = pay[i];
            csum = csum ^ b;
            wacc = {wacc[23:0], b};
            if (i % 4 == 3) begin
                sbq.push_back({AW'(widx), wacc});
                widx++;
            end
            send_byte(b);
        end
    endtask

    task automatic expect_status(input string tag, input logic d, input logic e);
        repeat (2) @(negedge clk);
        check({tag, "_done"}, 64'(bus.done), 64'(d));
        check({tag, "_err"}, 64'(bus.err), 64'(e));
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
        check({tag, "_sb_left"}, 64'(sbq.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 64'(bus.we), 64'd0);
        check({tag, "_waddr"}, 64'(bus.waddr), 64'd0);
        check({tag, "_wdata"}, 64'(bus.wdata), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Two-word frame with correct checksum
        {pay[0], pay[1], pay[2], pay[3], pay[4], pay[5], pay[6], pay[7]} =
            64'h3C08F060_AD000000;
        begin_frame();
        check("hdr_busy", 64'(bus.busy), 64'd1);
        send_hdr(32'd2);
        send_data(8);
        check("csum_model", 64'(csum), 64'h09);
        send_byte(csum);
        expect_status("t1", 1'b1, 1'b0);
        check("t1_waddr_hold", 64'(bus.waddr), 64'd1);
        check("t1_wdata_hold", 64'(bus.wdata), 64'hAD000000);

        // Same frame, bad checksum
        begin_frame();
        send_hdr(32'd2);
        send_data(8);
        send_byte(8'h00);
        expect_status("t2", 1'b0, 1'b1);

        // Oversized length
        we_before = n_we;
        begin_frame();
        send_hdr(32'h00000201);
        expect_status("t3", 1'b0, 1'b1);
        check("t3_no_we", 64'(n_we - we_before), 64'd0);

        // Empty frames
        begin_frame();
        send_hdr(32'd0);
        send_byte(8'h00);
        expect_status("t4a", 1'b1, 1'b0);
        begin_frame();
        send_hdr(32'd0);
        send_byte(8'h5A);
        expect_status("t4b", 1'b0, 1'b1);

        // Timeout mid-word
        we_before = n_we;
        begin_frame();
        send_hdr(32'd1);
        send_data(2);
        repeat (int'(TO) - 3) @(negedge clk);
        check("t5_busy_before", 64'(bus.busy), 64'd1);
        check("t5_err_before", 64'(bus.err), 64'd0);
        repeat (6) @(negedge clk);
        check("t5_err", 64'(bus.err), 64'd1);
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_done", 64'(bus.done), 64'd0);
        check("t5_no_we", 64'(n_we - we_before), 64'd0);

        // Reset mid-frame, then a clean reload with ignored start pulses
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
        begin_frame();
        send_hdr(32'd2);
        send_data(6);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("t6_rst");
        rst_n = 1'b1;
        begin_frame();
        send_hdr(32'd2);
        start_pulse();
        send_data(8);
        start_pulse();
        check("t6_busy_mid", 64'(bus.busy), 64'd1);
        send_byte(csum);
        expect_status("t6", 1'b1, 1'b0);

        // Full-depth frame reaches the last RAM word
        for (int i = 0; i < 2048; i++) pay[i] = 8'($urandom_range(0, 255));
        we_before = n_we;
        begin_frame();
        send_hdr(32'd512);
        send_data(2048);
        send_byte(csum);
        expect_status("t7", 1'b1, 1'b0);
        check("t7_we_count", 64'(n_we - we_before), 64'd512);
        check("t7_last_addr", 64'(bus.waddr), 64'd511);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
